z16_instr_encoder: RTL and testbench
====================================

Z16_INSTR_ENCODER -- requirements
Module: z16_instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, which sets the packed-word buffer depth (power of two, at least 2).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_start, input, 1 bit: begins a load session; honoured only in IDLE.
REQ-005 SHALL have port i_base_addr, input, 16 bits: first instruction-memory address, sampled on an accepted i_start.
REQ-006 SHALL have port i_valid, input, 1 bit: field tuple valid.
REQ-007 SHALL have port o_ready, output, 1 bit: encoder can accept a tuple.
REQ-008 SHALL have port i_last, input, 1 bit: marks the final tuple of a session; qualified by i_valid.
REQ-009 SHALL have ports i_opecode, i_rd_addr, i_rs1_addr and i_rs2_addr, inputs, 4 bits each: instruction fields.
REQ-010 SHALL have port i_imm, input, 16 bits: immediate in sign-extended form.
REQ-011 SHALL have port o_mem_wen, output, 1 bit: instruction-memory write strobe.
REQ-012 SHALL have port o_mem_addr, output, 16 bits: write address.
REQ-013 SHALL have port o_mem_wdata, output, 16 bits: packed instruction.
REQ-014 SHALL have port i_mem_busy, input, 1 bit: memory stall; no pop is made while it is high.
REQ-015 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 SHALL have port o_done, output, 1 bit: one-cycle end-of-session pulse.
REQ-017 SHALL have port o_err, output, 1 bit: sticky immediate-range error.
REQ-018 SHALL have port o_count, output, 16 bits: words written this session; wraps modulo 2^16.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN and DONE; IDLE goes to RUN on i_start, which also loads the address pointer from i_base_addr and clears o_count and o_err.
REQ-020 SHALL drive o_ready = (state == RUN) && !full; a tuple is accepted when i_valid && o_ready, and no tuple is accepted when full, even in a cycle that also pops.
REQ-021 SHALL pack opcode 4'hA as {i_imm[3:0], i_rs1_addr, i_rd_addr, 4'hA}.
REQ-022 SHALL pack opcode 4'hB as {i_rs2_addr, i_rs1_addr, i_imm[3:0], 4'hB}.
REQ-023 SHALL pack every other opcode as {i_rs2_addr, i_rs1_addr, i_rd_addr, i_opecode}.
REQ-024 SHALL move RUN to DRAIN on an accepted tuple with i_last=1.
REQ-025 SHALL pop the FIFO head in RUN or DRAIN when the FIFO is non-empty and i_mem_busy=0; in the next cycle o_mem_wen=1 for exactly one cycle, with o_mem_wdata = the popped word and o_mem_addr = the pointer, after which the pointer and o_count each increment by 1.
REQ-026 SHALL give minimum accept-to-write latency of 2 cycles: accepted at cycle N, o_mem_wen at N+2.
REQ-027 SHALL hold o_mem_wen=0 in any cycle with no pop in the previous cycle; o_mem_addr and o_mem_wdata hold their last values.
REQ-028 SHALL wrap the address pointer from 16'hFFFF to 16'h0000 without error.
REQ-029 SHALL move DRAIN to DONE once the FIFO is empty and no write is pending; DONE lasts exactly one cycle with o_done=1, then goes to IDLE.
REQ-030 SHALL ignore i_start outside IDLE; i_valid outside RUN is ignored.
REQ-031 SHALL reach DONE within one cycle of DRAIN when a session with i_last on the first tuple has already drained.

Reset
REQ-032 SHALL, when i_rst=1, force state to IDLE, empty the FIFO, and clear the pointer and o_count to 16'h0000, taking priority over all other events.
REQ-033 SHALL hold o_ready, o_mem_wen, o_busy, o_done and o_err at 0, and o_mem_addr and o_mem_wdata at 16'h0000, during and after reset.
REQ-034 SHALL, if reset occurs mid-session, produce no further write, including any word popped in the reset cycle.

Configuration
REQ-035 SHALL, with Z16_IMM_RANGE_CHECK_EN defined, set o_err on an accepted opcode 4'hA or 4'hB whose i_imm[15:4] != {12{i_imm[3]}}; the word is still encoded with i_imm[3:0], and o_err stays high until the next accepted i_start or reset.
REQ-036 SHALL, without Z16_IMM_RANGE_CHECK_EN, include no check logic and tie o_err to 0.

Verification
REQ-037 SHALL cover: start with base 16'h0010, then tuples (A, rd=1, rs1=2, imm=16'hFFFD) and (B, rs1=3, rs2=4, imm=16'h0002, last) -> writes 16'hD21A @0x0010 and 16'h432B @0x0011, then o_done pulse, o_count=2.
REQ-038 SHALL cover: R-type op=4'h0 with rd=5, rs1=6, rs2=7 -> o_mem_wdata=16'h7650, first write exactly 2 cycles after accept.
REQ-039 SHALL cover: i_mem_busy held high while 5 tuples are offered -> o_ready drops after FIFO_DEPTH(4) accepts; after release, 5 writes in order with no loss.
REQ-040 SHALL cover: base 16'hFFFF with 2 tuples -> writes at 16'hFFFF then 16'h0000.
REQ-041 SHALL cover: opcode A with imm=16'h0010 -> o_err=1 with the macro defined (wdata[15:12]=0), o_err=0 without it.
REQ-042 SHALL cover: i_rst asserted with 3 words buffered -> no further o_mem_wen, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/z16_instr_encoder.sv
// Instruction encoder: packs field tuples into 16-bit words, buffers them in a small FIFO
// and writes them to instruction memory. Optional macro: Z16_IMM_RANGE_CHECK_EN.
module z16_instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_base_addr,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_last,
    input  logic [3:0]  i_opecode,
    input  logic [3:0]  i_rd_addr,
    input  logic [3:0]  i_rs1_addr,
    input  logic [3:0]  i_rs2_addr,
    input  logic [15:0] i_imm,
    output logic        o_mem_wen,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic        i_mem_busy,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_count
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [15:0]   ptr_q, ptr_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   count_q, count_d;
    logic          wen_q, wen_d;
    logic          full, empty, accept, pop;
    logic [15:0]   packed_word;

    assign full    = (fill_q == FILL_MAX);
    assign empty   = (fill_q == '0);
    assign o_ready = !i_rst && (state_q == RUN) && !full;
    assign accept  = i_valid && o_ready;
    assign pop     = ((state_q == RUN) || (state_q == DRAIN)) && !empty && !i_mem_busy;

    always_comb begin
        case (i_opecode)
            4'hA:    packed_word = {i_imm[3:0], i_rs1_addr, i_rd_addr, 4'hA};
            4'hB:    packed_word = {i_rs2_addr, i_rs1_addr, i_imm[3:0], 4'hB};
            default: packed_word = {i_rs2_addr, i_rs1_addr, i_rd_addr, i_opecode};
        endcase
    end

    // Buffer storage carries no reset; emptiness is tracked by the pointers and fill level.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            fifo_mem[wr_ptr_q] <= packed_word;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        wen_d    = pop;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            wdata_d  = fifo_mem[rd_ptr_q];
            addr_d   = ptr_q;
            ptr_d    = ptr_q + 16'd1;
        end
        case ({accept, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
        // The write counter advances once the strobe cycle has completed.
        if (wen_q) begin
            count_d = count_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    ptr_d   = i_base_addr;
                    count_d = 16'h0000;
                end
            end
            RUN: begin
                if (accept && i_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Empty means nothing left to pop; a word popped last cycle is being written now.
                if (empty) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ptr_q    <= 16'h0000;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            count_q  <= 16'h0000;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
        end
    end

`ifdef Z16_IMM_RANGE_CHECK_EN
    logic err_q, err_d;
    logic imm_bad;

    assign imm_bad = ((i_opecode == 4'hA) || (i_opecode == 4'hB)) &&
                     (i_imm[15:4] != {12{i_imm[3]}});

    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && i_start) begin
            err_d = 1'b0;
        end else if (accept && imm_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = !i_rst && err_q;
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^i_imm[15:4];
    assign o_err = 1'b0;
`endif

    // Outputs read as their reset values while reset is asserted, not only after it.
    assign o_mem_wen   = !i_rst && wen_q;
    assign o_mem_addr  = i_rst ? 16'h0000 : addr_q;
    assign o_mem_wdata = i_rst ? 16'h0000 : wdata_q;
    assign o_busy      = !i_rst && (state_q != IDLE);
    assign o_done      = !i_rst && (state_q == DONE);
    assign o_count     = i_rst ? 16'h0000 : count_q;

endmodule

// File: tb/tb_z16_instr_encoder.sv
// Scoreboard bench for z16_instr_encoder: the driver queues expected writes from a
// field-level model, and a negedge monitor compares every memory write against the queue.
module tb_z16_instr_encoder;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_base_addr = 16'h0000;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_last = 1'b0;
    logic [3:0]  i_opecode = 4'h0, i_rd_addr = 4'h0, i_rs1_addr = 4'h0, i_rs2_addr = 4'h0;
    logic [15:0] i_imm = 16'h0000;
    logic        o_mem_wen;
    logic [15:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_busy = 1'b0;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_count;

    z16_instr_encoder #(.FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_valid(i_valid), .o_ready(o_ready), .i_last(i_last),
        .i_opecode(i_opecode), .i_rd_addr(i_rd_addr), .i_rs1_addr(i_rs1_addr),
        .i_rs2_addr(i_rs2_addr), .i_imm(i_imm),
        .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_busy(i_mem_busy), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          acc_cyc;
        bit          exact;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    logic [15:0] sess_base = 16'h0000;
    int          sess_idx = 0;
    bit          err_model = 1'b0;
    bit          rand_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Word layout straight from the field rules of each opcode class.
    function automatic logic [15:0] model_word(input logic [3:0] op, input logic [3:0] rd,
                                               input logic [3:0] rs1, input logic [3:0] rs2,
                                               input logic [15:0] imm);
        if (op == 4'hA) return {imm[3:0], rs1, rd, 4'hA};
        if (op == 4'hB) return {rs2, rs1, imm[3:0], 4'hB};
        return {rs2, rs1, rd, op};
    endfunction

    function automatic bit imm_out_of_range(input logic [15:0] imm);
        int v;
        v = int'($signed(imm));
        return (v < -8) || (v > 7);
    endfunction

    function automatic bit exp_err();
`ifdef Z16_IMM_RANGE_CHECK_EN
        return err_model;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard monitor.
    exp_t mon_e;
    always @(negedge clk) begin
        if (o_mem_wen === 1'b1) begin
            wr_seen++;
            $display("write addr=%h data=%h cyc=%0d", o_mem_addr, o_mem_wdata, cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%h data=%h required none",
                         o_mem_addr, o_mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(o_mem_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(o_mem_wdata), 32'(mon_e.data));
                if (mon_e.exact) chk("wr_latency", 32'(cyc - mon_e.acc_cyc), 32'd2);
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (rand_busy) i_mem_busy = ($urandom_range(0, 2) == 0);
    end

    // All driver tasks start and end at posedge + 1.
    task automatic start_session(input logic [15:0] base);
        i_start = 1'b1;
        i_base_addr = base;
        @(posedge clk); #1;
        i_start = 1'b0;
        sess_base = base;
        sess_idx = 0;
        err_model = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(o_busy), 32'd1);
        chk("err_cleared", 32'(o_err), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [15:0] imm, input bit last,
                        input bit exact);
        exp_t e;
        bit   took;
        i_valid = 1'b1; i_opecode = op; i_rd_addr = rd; i_rs1_addr = rs1;
        i_rs2_addr = rs2; i_imm = imm; i_last = last;
        took = 1'b0;
        for (int k = 0; k < 300 && !took; k++) begin
            @(negedge clk);
            if (o_ready === 1'b1) begin
                e.addr = sess_base + 16'(sess_idx);
                e.data = model_word(op, rd, rs1, rs2, imm);
                e.acc_cyc = cyc;
                e.exact = exact;
                exp_q.push_back(e);
                sess_idx++;
                if ((op == 4'hA || op == 4'hB) && imm_out_of_range(imm)) err_model = 1'b1;
                took = 1'b1;
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_last = 1'b0;
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted op=%h", op);
        end
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (o_done === 1'b1) got = 1'b1;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("done_count", 32'(o_count), 32'(sess_idx));
        chk("done_err", 32'(o_err), 32'(exp_err()));
        chk("drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_wen"}, 32'(o_mem_wen), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_err"}, 32'(o_err), 32'd0);
        chk({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(o_mem_wdata), 32'd0);
        chk({tag, "_count"}, 32'(o_count), 32'd0);
    endtask

    initial begin
        int          n, wr0;
        logic [3:0]  op;
        logic [15:0] imm;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("in_rst");
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");
        @(posedge clk); #1;

        // Two-instruction session, with a stray start pulse that must be ignored.
        start_session(16'h0010);
        send(4'hA, 4'd1, 4'd2, 4'd0, 16'hFFFD, 1'b0, 1'b0);
        i_start = 1'b1; i_base_addr = 16'h5555;
        @(posedge clk); #1;
        i_start = 1'b0;
        send(4'hB, 4'd0, 4'd3, 4'd4, 16'h0002, 1'b1, 1'b0);
        wait_done();

        // R-type with exact accept-to-write latency.
        start_session(16'h0200);
        send(4'h0, 4'd5, 4'd6, 4'd7, 16'h0000, 1'b1, 1'b1);
        wait_done();

        // Immediate outside the 4-bit signed range.
        start_session(16'h0300);
        send(4'hA, 4'd1, 4'd2, 4'd0, 16'h0010, 1'b1, 1'b0);
        wait_done();

        // Memory stalled while the buffer fills.
        start_session(16'h0100);
        i_mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(4'h3, 4'(i), 4'(i + 1), 4'(i + 2), 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ready_when_full", 32'(o_ready), 32'd0);
            @(posedge clk); #1;
        end
        i_mem_busy = 1'b0;
        send(4'h3, 4'd9, 4'd10, 4'd11, 16'h0, 1'b1, 1'b0);
        wait_done();

        // Address wrap.
        start_session(16'hFFFF);
        send(4'h1, 4'd1, 4'd1, 4'd1, 16'h0, 1'b0, 1'b0);
        send(4'h2, 4'd2, 4'd2, 4'd2, 16'h0, 1'b1, 1'b0);
        wait_done();

        // Randomised sessions with random memory stalls and valid gaps.
        for (int s = 0; s < 6; s++) begin
            start_session(16'($urandom));
            rand_busy = 1'b1;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       op = 4'hA;
                    1:       op = 4'hB;
                    default: op = 4'($urandom);
                endcase
                if ($urandom_range(0, 1) == 0) imm = 16'($signed(int'($urandom_range(0, 15)) - 8));
                else imm = 16'($urandom);
                send(op, 4'($urandom), 4'($urandom), 4'($urandom), imm, i == n - 1, 1'b0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            wait_done();
            rand_busy = 1'b0;
            i_mem_busy = 1'b0;
        end

        // Reset with buffered words; the pop in the reset cycle must not reach memory.
        start_session(16'h2000);
        i_mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) send(4'h4, 4'(i), 4'(i), 4'(i), 16'h0, 1'b0, 1'b0);
        i_rst = 1'b1;
        i_mem_busy = 1'b0;
        wr0 = wr_seen;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_write_after_rst", 32'(wr_seen - wr0), 32'd0);
        check_reset_outputs("after_mid_rst");
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
